// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes,
// ALU operation codes, FSM state encodings and the opcode class record.
package cpu_pkg;

  // Instruction opcodes (IR[15:12])
  localparam logic [3:0] OP_LOGIC  = 4'b0000;
  localparam logic [3:0] OP_ADDSUB = 4'b0001;
  localparam logic [3:0] OP_SHIFT  = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_SLTI   = 4'b1011;
  localparam logic [3:0] OP_LW     = 4'b1100;
  localparam logic [3:0] OP_SW     = 4'b1101;
  localparam logic [3:0] OP_BEQ    = 4'b1111;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;  // address calculation
  localparam logic [1:0] ALU_CMP   = 2'b01;  // BEQ compare
  localparam logic [1:0] ALU_RTYPE = 2'b10;  // function field decides
  localparam logic [1:0] ALU_ITYPE = 2'b11;  // opcode decides

  // Sequencer states; the encoding is visible on the debug port
  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_e;

  // One-hot classification of an opcode
  typedef struct packed {
    logic is_rtype;
    logic is_itype_alu;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_illegal;
  } op_class_t;

  // Anything not explicitly recognised is classified as illegal
  localparam op_class_t OP_CLASS_ILLEGAL = '{
    is_rtype:     1'b0,
    is_itype_alu: 1'b0,
    is_lw:        1'b0,
    is_sw:        1'b0,
    is_beq:       1'b0,
    is_illegal:   1'b1
  };

endpackage

// File: rtl/mcu_decode.sv
// Combinational opcode classifier for the multi-cycle control sequencer.
module mcu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_rtype,
  output logic       is_itype_alu,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_illegal
);

  op_class_t w_class;

  // Map each opcode to exactly one class; unknown codes fall to illegal
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    w_class = OP_CLASS_ILLEGAL;
    case (opcode)
      OP_LOGIC, OP_ADDSUB, OP_SHIFT: w_class = '{is_rtype: 1'b1, default: 1'b0};
      OP_ADDI, OP_SUBI, OP_SLTI:     w_class = '{is_itype_alu: 1'b1, default: 1'b0};
      OP_LW:                         w_class = '{is_lw: 1'b1, default: 1'b0};
      OP_SW:                         w_class = '{is_sw: 1'b1, default: 1'b0};
      OP_BEQ:                        w_class = '{is_beq: 1'b1, default: 1'b0};
      default:                       w_class = OP_CLASS_ILLEGAL;
    endcase
  end

  assign is_rtype     = w_class.is_rtype;
  assign is_itype_alu = w_class.is_itype_alu;
  assign is_lw        = w_class.is_lw;
  assign is_sw        = w_class.is_sw;
  assign is_beq       = w_class.is_beq;
  assign is_illegal   = w_class.is_illegal;

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables each cycle.
module multicycle_cu
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ior_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [2:0] state
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e          r_state;
  state_e          w_next;
  logic [3:0]      r_opcode;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_timeout;

  logic [3:0]      w_dec_op;
  logic            w_is_rtype;
  logic            w_is_itype_alu;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_is_beq;
  logic            w_is_illegal;

  // The branch decision on alu_zero is taken in the datapath, which gates
  // pc_write_cond with the flag; the sequencer itself never needs it.
  logic            w_unused_alu_zero;
  assign w_unused_alu_zero = alu_zero;

  // DECODE classifies the live IR field; later states use the latched copy
  assign w_dec_op = (r_state == S_DECODE) ? opcode : r_opcode;

  mcu_decode u_decode (
    .opcode       (w_dec_op),
    .is_rtype     (w_is_rtype),
    .is_itype_alu (w_is_itype_alu),
    .is_lw        (w_is_lw),
    .is_sw        (w_is_sw),
    .is_beq       (w_is_beq),
    .is_illegal   (w_is_illegal)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Opcode latch, loaded once per instruction in DECODE
  always_ff @(posedge clk) begin
    if (rst)                      r_opcode <= '0;
    else if (r_state == S_DECODE) r_opcode <= opcode;
  end

  // Memory wait counter and sticky timeout flag; the request is never aborted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (mem_req) begin
      if (mem_ack) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != CW'(WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == CW'(WAIT_MAX - 1)) r_timeout <= 1'b1;
      end
    end
  end

  // Next-state and Moore outputs; reset forces every output low at once
  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ior_d         = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            if (mem_ack) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              w_next   = S_DECODE;
            end
          end
        end

        S_DECODE: begin
          if (w_is_illegal) begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next     = S_EXEC;
          end
        end

        S_EXEC: begin
          if (w_is_rtype) begin
            alu_src = 1'b0;
            alu_op  = ALU_RTYPE;
            w_next  = S_WB;
          end else if (w_is_itype_alu) begin
            alu_src = 1'b1;
            alu_op  = ALU_ITYPE;
            w_next  = S_WB;
          end else if (w_is_lw || w_is_sw) begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            w_next  = S_MEM;
          end else if (w_is_beq) begin
            alu_src       = 1'b0;
            alu_op        = ALU_CMP;
            pc_write_cond = 1'b1;
            instr_done    = 1'b1;
            w_next        = S_FETCH;
          end else begin
            w_next  = S_FETCH;
          end
        end

        S_MEM: begin
          mem_req = 1'b1;
          ior_d   = 1'b1;
          mem_we  = w_is_sw;
          if (mem_ack) begin
            if (w_is_sw) begin
              instr_done = 1'b1;
              w_next     = S_FETCH;
            end else begin
              w_next     = S_WB;
            end
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = w_is_rtype;
          mem_to_reg = w_is_lw;
          w_next     = S_FETCH;
        end

        default: w_next = S_FETCH;
      endcase
    end
  end

  assign mem_timeout = r_timeout & ~rst;
  assign state       = rst ? S_FETCH : r_state;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboard bench for multicycle_cu: each stimulus cycle pushes its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       mem_ack;
  logic       mem_req, mem_we, ior_d, ir_write, pc_write, pc_write_cond;
  logic       reg_dst, alu_src, mem_to_reg, reg_write, instr_done;
  logic       illegal_op, mem_timeout;
  logic [1:0] alu_op;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, iord, irw, pcw, pcc, rdst, asrc;
    logic [1:0] aop;
    logic       m2r, rw, done, ill, to;
  } out_t;

  out_t  act;
  out_t  exp_q[$];
  string tag_q[$];
  out_t  m_exp;
  string m_tag;
  int    n_checks = 0;
  int    n_pass   = 0;

  multicycle_cu #(.WAIT_MAX(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .alu_zero      (alu_zero),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .ior_d         (ior_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .reg_dst       (reg_dst),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .mem_timeout   (mem_timeout),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign act = {state, mem_req, mem_we, ior_d, ir_write, pc_write, pc_write_cond,
                reg_dst, alu_src, alu_op, mem_to_reg, reg_write, instr_done,
                illegal_op, mem_timeout};

  function automatic out_t mk(input logic [2:0] st, input logic req, we, iord, irw,
                              pcw, pcc, rdst, asrc, input logic [1:0] aop,
                              input logic m2r, rw, done, ill, to);
    return {st, req, we, iord, irw, pcw, pcc, rdst, asrc, aop, m2r, rw, done, ill, to};
  endfunction

  // Named vectors for the recurring cycles
  function automatic out_t idle();
    return mk(3'd0, 0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0,0);
  endfunction
  function automatic out_t fetch(input logic acked, input logic to);
    return mk(3'd0, 1,0,0,acked,acked,0,0,0, 2'b00, 0,0,0,0,to);
  endfunction
  function automatic out_t dec(input logic ill, input logic to);
    return mk(3'd1, 0,0,0,0,0,0,0,0, 2'b00, 0,0,0,ill,to);
  endfunction

  // One clock of stimulus plus its expected output vector
  task automatic step(input string tag, input logic r, ru, input logic [3:0] op,
                      input logic ack, z, input out_t e);
    rst      = r;
    run      = ru;
    opcode   = op;
    mem_ack  = ack;
    alu_zero = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      n_checks++;
      if (act === m_exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", m_tag, act, m_exp);
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 4'h0; mem_ack = 1'b0; alu_zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset cycle: outputs forced low even with run and ack high
    step("reset",        1,1,4'h0,1,0, idle());

    // R-type add/sub, zero-wait; opcode input changes after DECODE
    step("r_fetch",      0,1,4'h0,1,0, fetch(1,0));
    step("r_decode",     0,1,4'h1,0,0, dec(0,0));
    step("r_exec",       0,1,4'h4,1,0, mk(3'd2, 0,0,0,0,0,0,0,0, 2'b10, 0,0,0,0,0));
    step("r_wb",         0,1,4'h4,0,0, mk(3'd4, 0,0,0,0,0,0,1,0, 2'b00, 0,1,1,0,0));

    // LW with two wait cycles in MEM: 7 cycles total
    step("lw_fetch",     0,1,4'h0,1,0, fetch(1,0));
    step("lw_decode",    0,1,4'hC,0,0, dec(0,0));
    step("lw_exec",      0,1,4'hC,0,0, mk(3'd2, 0,0,0,0,0,0,0,1, 2'b00, 0,0,0,0,0));
    step("lw_mem_w1",    0,1,4'hC,0,0, mk(3'd3, 1,0,1,0,0,0,0,0, 2'b00, 0,0,0,0,0));
    step("lw_mem_w2",    0,1,4'hC,0,0, mk(3'd3, 1,0,1,0,0,0,0,0, 2'b00, 0,0,0,0,0));
    step("lw_mem_ack",   0,1,4'hC,1,0, mk(3'd3, 1,0,1,0,0,0,0,0, 2'b00, 0,0,0,0,0));
    step("lw_wb",        0,1,4'hC,0,0, mk(3'd4, 0,0,0,0,0,0,0,0, 2'b00, 1,1,1,0,0));

    // SW, zero-wait: write in MEM, done on ack, no reg_write
    step("sw_fetch",     0,1,4'h0,1,0, fetch(1,0));
    step("sw_decode",    0,1,4'hD,0,0, dec(0,0));
    step("sw_exec",      0,1,4'hD,0,0, mk(3'd2, 0,0,0,0,0,0,0,1, 2'b00, 0,0,0,0,0));
    step("sw_mem_ack",   0,1,4'hD,1,0, mk(3'd3, 1,1,1,0,0,0,0,0, 2'b00, 0,0,1,0,0));

    // BEQ with alu_zero=1: 3 cycles
    step("beq_fetch",    0,1,4'h0,1,0, fetch(1,0));
    step("beq_decode",   0,1,4'hF,0,0, dec(0,0));
    step("beq_exec",     0,1,4'hF,0,1, mk(3'd2, 0,0,0,0,0,1,0,0, 2'b01, 0,0,1,0,0));

    // Illegal opcode 0100: pulse in DECODE, then FETCH (held with run=0)
    step("ill_fetch",    0,1,4'h0,1,0, fetch(1,0));
    step("ill_decode",   0,1,4'h4,0,0, dec(1,0));
    step("ill_next",     0,0,4'h4,0,0, idle());

    // Shift R-type: alu_src must be a clean 0
    step("sh_fetch",     0,1,4'h0,1,0, fetch(1,0));
    step("sh_decode",    0,1,4'h2,0,0, dec(0,0));
    step("sh_exec",      0,1,4'h2,0,0, mk(3'd2, 0,0,0,0,0,0,0,0, 2'b10, 0,0,0,0,0));
    step("sh_wb",        0,1,4'h2,0,0, mk(3'd4, 0,0,0,0,0,0,1,0, 2'b00, 0,1,1,0,0));

    // ADDI: immediate operand, write to rt
    step("addi_fetch",   0,1,4'h0,1,0, fetch(1,0));
    step("addi_decode",  0,1,4'h9,0,0, dec(0,0));
    step("addi_exec",    0,1,4'h9,0,0, mk(3'd2, 0,0,0,0,0,0,0,1, 2'b11, 0,0,0,0,0));
    step("addi_wb",      0,1,4'h9,0,0, mk(3'd4, 0,0,0,0,0,0,0,0, 2'b00, 0,1,1,0,0));

    // FETCH ack withheld for WAIT_MAX cycles, then a late ack
    for (int i = 0; i < 15; i++)
      step("fetch_wait", 0,1,4'h0,0,0, fetch(0,0));
    step("timeout_set",  0,1,4'h0,0,0, fetch(0,1));
    step("late_ack",     0,1,4'h0,1,0, fetch(1,1));
    step("to_decode",    0,1,4'h1,0,0, dec(0,1));
    step("to_exec",      0,1,4'h1,0,0, mk(3'd2, 0,0,0,0,0,0,0,0, 2'b10, 0,0,0,0,1));
    step("to_wb",        0,1,4'h1,0,0, mk(3'd4, 0,0,0,0,0,0,1,0, 2'b00, 0,1,1,0,1));

    // Reset while LW waits in MEM: request dropped, timeout cleared
    step("rl_fetch",     0,1,4'h0,1,0, fetch(1,1));
    step("rl_decode",    0,1,4'hC,0,0, dec(0,1));
    step("rl_exec",      0,1,4'hC,0,0, mk(3'd2, 0,0,0,0,0,0,0,1, 2'b00, 0,0,0,0,1));
    step("rl_mem_wait",  0,1,4'hC,0,0, mk(3'd3, 1,0,1,0,0,0,0,0, 2'b00, 0,0,0,0,1));
    step("rst_in_mem",   1,1,4'hC,0,0, idle());
    step("after_rst",    0,0,4'hC,1,0, idle());
    step("run_low_hold", 0,0,4'h0,1,0, idle());
    step("restart",      0,1,4'h0,1,0, fetch(1,0));

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle control sequencer for the 16-bit CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states over a shared instruction/data memory port. Each cycle it drives the datapath enables: PC, IR, register file, ALU operand/op select and memory request. It replaces single-cycle decode in the multi-cycle datapath variant.

## Interface
Parameters:
- WAIT_MAX, 15: max cycles a memory request may wait for mem_ack before mem_timeout is flagged.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  when high, FETCH may start a new instruction; sampled only in FETCH.
- opcode  in  4  IR[15:12]; valid from the cycle after ir_write.
- alu_zero  in  1  ALU zero flag; used in EXEC of BEQ.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = write (SW), 0 = read; valid while mem_req.
- ior_d  out  1  0 = address from PC, 1 = address from ALU result register.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC unconditionally (PC+2).
- pc_write_cond  out  1  load PC with branch target if alu_zero.
- reg_dst  out  1  1 = rd field, 0 = rt field.
- alu_src  out  1  1 = sign-extended immediate, 0 = register B.
- alu_op  out  2  00 add (address), 01 compare (BEQ), 10 R-type by funct, 11 I-type by opcode.
- mem_to_reg  out  1  1 = write-back from memory data register.
- reg_write  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- mem_timeout  out  1  sticky; cleared only by rst.
- state  out  3  current state encoding, for debug.

## Operation
- Opcodes: 0000 logic R, 0001 add/sub R, 0010 shift R, 1001 ADDI, 1010 SUBI, 1011 SLTI, 1100 LW, 1101 SW, 1111 BEQ. All others are illegal.
- FETCH:
  - If run=0, hold with all outputs 0.
  - Otherwise assert mem_req, ior_d=0, mem_we=0.
  - On mem_ack: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
- DECODE: latch opcode into an internal register; all later states use the latched value.
  - Illegal opcode: pulse illegal_op, go to FETCH, no other enables.
  - Otherwise go to EXEC.
- EXEC:
  - R types: alu_src=0, alu_op=10; go to WB.
  - I-type ALU: alu_src=1, alu_op=11; go to WB.
  - LW/SW: alu_src=1, alu_op=00; go to MEM.
  - BEQ: alu_src=0, alu_op=01, pc_write_cond=1, instr_done=1; go to FETCH.
- MEM: mem_req=1, ior_d=1, mem_we=1 for SW and 0 for LW; hold until mem_ack.
  - LW: go to WB on ack.
  - SW: on ack pulse instr_done and go to FETCH.
- WB: reg_write=1 and instr_done=1; go to FETCH.
  - R types: reg_dst=1, mem_to_reg=0.
  - I-type ALU: reg_dst=0, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
- Shift instructions drive alu_src=0, never X.

## Timing
- Outputs are Moore-style, decoded from state and the latched opcode. The only exception is ir_write, pc_write, the MEM-exit instr_done and the FETCH/MEM exit transitions, which are qualified by mem_ack in the same cycle.
- Zero-wait memory: mem_ack may arrive in the first cycle of mem_req.
- Latency in cycles with zero-wait memory:
  - BEQ: 3.
  - R-type, I-type ALU and SW: 4.
  - LW: 5.
  - Illegal opcode: 2.
- Each wait cycle adds 1.
- mem_ack is ignored while mem_req=0.
- Wait counter: counts cycles with mem_req=1 and mem_ack=0.
  - Reaching WAIT_MAX sets mem_timeout; the request stays held and is not aborted.
  - The counter clears on ack.
- Reset:
  - Any state goes to FETCH on the next edge.
  - All outputs are 0 in the reset cycle and after it; mem_timeout, the opcode latch and the wait counter are cleared.
  - An in-flight mem_req drops immediately; the memory must tolerate an abandoned request.
- run going low mid-instruction has no effect until the FETCH state.
- State encoding: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100. Unused codes recover to FETCH.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams
  - alu_op codes
  - state encodings
  - the illegal-opcode default
- One sub-module, mcu_decode: a combinational opcode classifier. Outputs is_rtype, is_itype_alu, is_lw, is_sw, is_beq, is_illegal.
- The FSM and wait counter stay in multicycle_cu.

## Test plan
- Reset, then run=1, opcode=0001, zero-wait ack → states FETCH, DECODE, EXEC, WB. WB has reg_write=1 and reg_dst=1. instr_done pulses in cycle 4.
- LW (1100) with 2 wait cycles in MEM → mem_req held 3 cycles with ior_d=1 and mem_we=0. WB has mem_to_reg=1 and reg_dst=0. Total 7 cycles.
- SW (1101) → MEM has mem_we=1 and reg_write never asserts. BEQ (1111) with alu_zero=1 → pc_write_cond=1 in cycle 3, then back to FETCH.
- Opcode 0100 → illegal_op pulses in DECODE, no reg_write or mem_req, next state FETCH. Opcode 0010 → alu_src=0 (not X).
- Withhold mem_ack in FETCH for WAIT_MAX cycles → mem_timeout set and sticky, mem_req still high. A later ack completes normally.
- Assert rst during MEM of LW → next cycle state=000, all outputs 0, mem_timeout cleared. run=0 after reset → FETCH held, mem_req=0.
